// File: rtl/tag_alloc_pkg.sv
// Shared types and constants for the 64-entry tag allocator.
// Optional double-free checking in tag_alloc_ctl is enabled with TAG_ALLOC_CHECK_EN.
package tag_alloc_pkg;

    localparam int NTAG = 64;
    localparam int TW   = 6;

    typedef logic [TW-1:0]   tag_t;
    typedef logic [NTAG-1:0] tag_map_t;
    typedef logic [TW:0]     tag_cnt_t;

    function automatic tag_map_t tag_onehot(input tag_t tag);
        tag_map_t m;
        m = '0;
        m[tag] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/tag_alloc_prio_enc.sv
// Purely combinational lowest-set-bit finder over a 64-bit map, built as a
// two-level 8x8 find-first (first non-empty byte, then first bit inside it).
module tag_prio_enc
    import tag_alloc_pkg::*;
(
    input  tag_map_t map,
    output tag_t     idx,
    output logic     any_set
);

    logic [7:0] grp_any;
    logic [2:0] grp_idx;
    logic [7:0] sel_byte;
    logic [2:0] bit_idx;

    // Scanning downward so the last hit written is the lowest index.
    always_comb begin
        grp_any = '0;
        grp_idx = '0;
        for (int g = 0; g < 8; g++) begin
            grp_any[g] = |map[g*8 +: 8];
        end
        for (int g = 7; g >= 0; g--) begin
            if (grp_any[g]) begin
                grp_idx = g[2:0];
            end
        end
    end

    always_comb begin
        sel_byte = map[grp_idx*8 +: 8];
        bit_idx  = '0;
        for (int b = 7; b >= 0; b--) begin
            if (sel_byte[b]) begin
                bit_idx = b[2:0];
            end
        end
    end

    assign idx     = {grp_idx, bit_idx};
    assign any_set = |grp_any;

endmodule

// File: rtl/tag_alloc_ctl.sv
// 64-entry tag allocator: lowest free tag via valid/ready, two releases per cycle,
// synchronous flush. Define TAG_ALLOC_CHECK_EN to add the sticky dbl_free flag.
module tag_alloc_ctl
    import tag_alloc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       alloc_valid,
    output logic       alloc_ready,
    output logic [5:0] alloc_tag,
    input  logic       free0_valid,
    input  logic [5:0] free0_tag,
    input  logic       free1_valid,
    input  logic [5:0] free1_tag,
    output logic [6:0] free_cnt,
    output logic       empty
`ifdef TAG_ALLOC_CHECK_EN
    ,
    output logic       dbl_free
`endif
);

    tag_map_t free_map_q, free_map_d;
    tag_cnt_t free_cnt_q, free_cnt_d;
    logic     empty_q, empty_d;

    tag_t     pick_tag;
    logic     any_free;
    logic     grant;
    logic     same_tag;
    logic     rel0, rel1;
    tag_map_t grant_mask, rel_mask;

    tag_prio_enc u_enc (
        .map     (free_map_q),
        .idx     (pick_tag),
        .any_set (any_free)
    );

    assign alloc_ready = any_free & ~flush;
    assign alloc_tag   = pick_tag;
    assign grant       = alloc_valid & alloc_ready;
    assign same_tag    = free0_valid & free1_valid & (free0_tag == free1_tag);

    // Only tags that really go 0->1 count; port 1 defers to port 0 on a shared tag.
    assign rel0 = free0_valid & ~free_map_q[free0_tag];
    assign rel1 = free1_valid & ~free_map_q[free1_tag] & ~same_tag;

    always_comb begin
        grant_mask = grant ? tag_onehot(pick_tag) : '0;
        rel_mask   = '0;
        if (rel0) begin
            rel_mask = rel_mask | tag_onehot(free0_tag);
        end
        if (rel1) begin
            rel_mask = rel_mask | tag_onehot(free1_tag);
        end

        free_map_d = (free_map_q & ~grant_mask) | rel_mask;
        free_cnt_d = free_cnt_q - {{TW{1'b0}}, grant}
                   + {{TW{1'b0}}, rel0} + {{TW{1'b0}}, rel1};
        if (flush) begin
            free_map_d = '1;
            free_cnt_d = tag_cnt_t'(NTAG);
        end
        empty_d = (free_cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map_q <= '1;
            free_cnt_q <= tag_cnt_t'(NTAG);
            empty_q    <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            free_cnt_q <= free_cnt_d;
            empty_q    <= empty_d;
        end
    end

    assign free_cnt = free_cnt_q;
    assign empty    = empty_q;

`ifdef TAG_ALLOC_CHECK_EN
    logic dbl_free_q, dbl_free_d;
    logic dbl_event;

    // Flush does not mask the check: a bad release is reported whatever else happens.
    assign dbl_event = (free0_valid & free_map_q[free0_tag])
                     | (free1_valid & free_map_q[free1_tag])
                     | same_tag;

    always_comb begin
        dbl_free_d = dbl_free_q | dbl_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbl_free_q <= 1'b0;
        end else begin
            dbl_free_q <= dbl_free_d;
        end
    end

    assign dbl_free = dbl_free_q;

    a_no_dbl_free: assert property (@(posedge clk) disable iff (rst) !dbl_event)
        else $error("tag_alloc_ctl: double free of tag (port0=%0d port1=%0d)", free0_tag, free1_tag);
`endif

endmodule

// File: tb/tb_tag_alloc_ctl.sv
// Directed, table-driven bench for tag_alloc_ctl; checks dbl_free too when
// built with TAG_ALLOC_CHECK_EN.
module tb_tag_alloc_ctl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [5:0] alloc_tag;
    logic       free0_valid;
    logic [5:0] free0_tag;
    logic       free1_valid;
    logic [5:0] free1_tag;
    logic [6:0] free_cnt;
    logic       empty;
    logic       dbl_free;

    int vec_count;
    int miscompares;

    tag_alloc_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .free0_valid (free0_valid),
        .free0_tag   (free0_tag),
        .free1_valid (free1_valid),
        .free1_tag   (free1_tag),
        .free_cnt    (free_cnt),
        .empty       (empty)
`ifdef TAG_ALLOC_CHECK_EN
        ,
        .dbl_free    (dbl_free)
`endif
    );

`ifndef TAG_ALLOC_CHECK_EN
    assign dbl_free = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic       fl;
        logic       f0v;
        logic [5:0] f0t;
        logic       f1v;
        logic [5:0] f1t;
        logic       exp_ready;
        logic [5:0] exp_tag;
        logic [6:0] exp_cnt;
        logic       exp_empty;
        logic       exp_dbl;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    // Drives inputs just after the falling edge so outputs settle well before the rising edge.
    task automatic applyStimulus(input logic av, input logic fl,
                                 input logic f0v, input logic [5:0] f0t,
                                 input logic f1v, input logic [5:0] f1t);
        @(negedge clk);
        alloc_valid = av;
        flush       = fl;
        free0_valid = f0v;
        free0_tag   = f0t;
        free1_valid = f1v;
        free1_tag   = f1t;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic er, input logic [5:0] et,
                               input logic [6:0] ec, input logic ee, input logic ed);
        logic bad;
        vec_count++;
        bad = (alloc_ready !== er) || (alloc_tag !== et) || (free_cnt !== ec) || (empty !== ee);
`ifdef TAG_ALLOC_CHECK_EN
        bad = bad || (dbl_free !== ed);
`endif
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got ready=%0b tag=%0d cnt=%0d empty=%0b dbl=%0b, want ready=%0b tag=%0d cnt=%0d empty=%0b dbl=%0b",
                     name, alloc_ready, alloc_tag, free_cnt, empty, dbl_free, er, et, ec, ee, ed);
        end
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        free0_valid = 1'b0;
        free0_tag   = '0;
        free1_valid = 1'b0;
        free1_tag   = '0;

        // State before v0: all 64 tags allocated, count 0, empty.
        //          av fl f0v f0t f1v f1t  rdy tag cnt emp dbl
        vecs[0]  = '{0, 0, 1, 17, 1,  5,  0,  0,  0, 1, 0};
        vecs[1]  = '{0, 0, 0,  0, 0,  0,  1,  5,  2, 0, 0};
        vecs[2]  = '{1, 0, 0,  0, 0,  0,  1,  5,  2, 0, 0};
        vecs[3]  = '{0, 0, 0,  0, 0,  0,  1, 17,  1, 0, 0};
        vecs[4]  = '{1, 0, 1,  9, 0,  0,  1, 17,  1, 0, 0};
        vecs[5]  = '{0, 0, 0,  0, 0,  0,  1,  9,  1, 0, 0};
        vecs[6]  = '{1, 0, 1, 40, 0,  0,  1,  9,  1, 0, 0};
        vecs[7]  = '{0, 0, 0,  0, 0,  0,  1, 40,  1, 0, 0};
        vecs[8]  = '{0, 0, 1, 12, 1, 12,  1, 40,  1, 0, 0};
        vecs[9]  = '{0, 0, 0,  0, 0,  0,  1, 12,  2, 0, 1};
        vecs[10] = '{0, 0, 1, 40, 0,  0,  1, 12,  2, 0, 1};
        vecs[11] = '{0, 0, 0,  0, 0,  0,  1, 12,  2, 0, 1};
        vecs[12] = '{1, 0, 1,  3, 1,  4,  1, 12,  2, 0, 1};
        vecs[13] = '{0, 0, 0,  0, 0,  0,  1,  3,  3, 0, 1};
        vecs[14] = '{1, 1, 1, 40, 0,  0,  0,  3,  3, 0, 1};
        vecs[15] = '{0, 0, 0,  0, 0,  0,  1,  0, 64, 0, 1};
        vecs[16] = '{1, 0, 0,  0, 0,  0,  1,  0, 64, 0, 1};
        vecs[17] = '{0, 0, 0,  0, 0,  0,  1,  1, 63, 0, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("reset_state", 1'b1, 6'd0, 7'd64, 1'b0, 1'b0);

        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput($sformatf("drain_%0d", i), 1'b1, 6'(i), 7'(64 - i), 1'b0, 1'b0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("drained", 1'b0, 6'd0, 7'd0, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drained_hold", 1'b0, 6'd0, 7'd0, 1'b1, 1'b0);

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].av, vecs[v].fl, vecs[v].f0v, vecs[v].f0t,
                          vecs[v].f1v, vecs[v].f1t);
            checkOutput($sformatf("vec_%0d", v), vecs[v].exp_ready, vecs[v].exp_tag,
                        vecs[v].exp_cnt, vecs[v].exp_empty, vecs[v].exp_dbl);
        end

        // Async reset mid-stream: restart from a clean state, take 30 tags, then hit rst between edges.
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput($sformatf("prealloc_%0d", i), 1'b1, 6'(i), 7'(64 - i), 1'b0, 1'b0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("thirty_out", 1'b1, 6'd30, 7'd34, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 1'b1, 6'd0, 7'd64, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("post_reset_grant", 1'b1, 6'd0, 7'd64, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_next", 1'b1, 6'd1, 7'd63, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/tag_alloc_ctl.md
# tag_alloc_ctl

64-entry tag allocator built around a lowest-set-bit priority encoder. It keeps a free bitmap and hands out the lowest-numbered free tag through a valid/ready handshake. It accepts up to two tag releases per cycle and supports a synchronous flush. It sits between the dispatch stage (allocate side) and the retire/writeback stages (release side), and sequences all use of the shared 64-tag resource.

## Interface
- NTAG, 64, number of tags; fixed at 64 (bitmap and encoder are 64 wide)
- TW, 6, tag width (log2 NTAG)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; return all tags to free
- alloc_valid  input  1  requester wants one tag this cycle
- alloc_ready  output  1  a tag is available and flush is low
- alloc_tag  output  6  tag granted; valid while alloc_ready is high
- free0_valid / free1_valid  input  1 each  release strobes
- free0_tag / free1_tag  input  6 each  tags being released
- free_cnt  output  7  number of free tags, 0..64 (registered)
- empty  output  1  registered, free_cnt==0
- dbl_free  output  1  sticky error flag; present only with TAG_ALLOC_CHECK_EN

## Operation
- State: free_map[63:0] (1 = free), free_cnt[6:0], optional dbl_free.
- Reset (async): free_map = all ones, free_cnt = 64, empty = 0, dbl_free = 0. Combinational outputs after reset: alloc_ready = 1, alloc_tag = 0.
- Pick: alloc_tag = index of the lowest set bit of free_map. When free_map == 0, alloc_tag = 0.
- alloc_ready = (free_map != 0) & ~flush.
- A grant occurs when alloc_valid & alloc_ready. On the next edge the granted bit clears.
- A free on port k sets free_map[freek_tag] on the next edge.
- If both free ports carry the same tag in one cycle, the tag is set once and counted once.
- Count update: free_cnt_next = free_cnt − grant + (number of distinct tags actually transitioning 0→1). Clamp is never needed for legal traffic.
- A free of an already-free tag is a double free. The bitmap stays set and the count does not change.
- Flush has priority over grant and frees in the same cycle. Next state: all ones, count 64. Grants are blocked because alloc_ready is low.
- No bypass: a tag freed in cycle N is allocatable from cycle N+1 at the earliest.

## Timing
- Allocate latency: 0 cycles. alloc_tag/alloc_ready depend combinationally on free_map and flush only, never on alloc_valid.
- Release latency: 1 cycle to visibility in free_map, alloc_tag and free_cnt.
- Throughput: 1 grant and 2 frees per cycle, sustained.
- free_cnt and empty are registered. They reflect grants and frees of the previous cycle.
- Empty boundary: with 1 free tag and grant plus free of another tag in the same cycle, the next cycle has exactly that other tag free and free_cnt = 1.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values. Grants in flight are lost.

## Configuration
- TAG_ALLOC_CHECK_EN defined:
  - dbl_free port exists.
  - It sets on any free of a tag whose free_map bit is already 1. It also sets on both ports freeing the same tag in one cycle.
  - It stays set until rst. Flush does not clear it.
  - A simulation assertion fires on the setting event.
- Macro undefined: no dbl_free port and no check logic. Double frees are silently absorbed as above.

## Structure
- Package tag_alloc_pkg:
  - constants NTAG = 64, TW = 6
  - typedef tag_t (logic [TW-1:0])
  - typedef tag_map_t (logic [NTAG-1:0])
  - typedef tag_cnt_t (logic [TW:0])
- Sub-module tag_prio_enc: purely combinational. Input is a 64-bit map; outputs are the 6-bit lowest-set index and any_set. It is implemented as a two-level 8×8 find-first. It is instantiated once on free_map.
- Everything else (bitmap, counter, popcount of releases, check) lives in tag_alloc_ctl.

## Test plan
- Reset, then alloc_valid held for 64 cycles:
  - tags granted are 0,1,…,63 in order
  - free_cnt reaches 0 and empty = 1
  - alloc_ready = 0 from then on
- All tags allocated, then free 17 and free 5 in the same cycle:
  - next cycle free_cnt = 2 and alloc_tag = 5
  - after granting 5, alloc_tag = 17
- One tag free (tag 9): grant 9 while freeing 40 in the same cycle:
  - next cycle free_cnt = 1 and alloc_tag = 40
- Both ports free tag 12 in one cycle (12 allocated):
  - free_cnt increments by 1
  - with TAG_ALLOC_CHECK_EN, dbl_free = 1
- Flush asserted together with alloc_valid and free0 of a free tag:
  - alloc_ready = 0 that cycle
  - next cycle free_cnt = 64 and alloc_tag = 0
  - with macro, dbl_free = 1
- Assert rst asynchronously mid-stream with 30 tags allocated:
  - immediately free_cnt = 64, alloc_tag = 0, dbl_free = 0
